mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// Word-addressed synchronous RAM acting as the memory-side responder to the datapath's MAR/MDR port.
// Captures the MAR address and MDR write data on a request, performs the access after a fixed latency,
// and drives read data back onto the datapath MdataIn input.
// A 4-phase req/done handshake lets the control unit stall until the access completes.
// PARAMETERS
// ADDR_W   9    word address width; depth = 2**ADDR_W words (512)
// LATENCY  2    cycles from request accept to done; legal 1..15
// PORTS
// clk       in   1   system clock, rising edge
// clr       in   1   asynchronous active-low reset
// mem_read  in   1   read request strobe (level, held until done seen)
// mem_write in   1   write request strobe (level, held until done seen)
// address   in   32  word address, from MAR output
// data_in   in   32  write data, from MDR output
// data_out  out  32  read data, to datapath MdataIn
// mem_done  out  1   access complete; high until both strobes drop
// busy      out  1   access accepted and in progress
// addr_err  out  1   completed access had an out-of-range address; valid while mem_done
// BEHAVIOUR
// - Reset (clr=0, async): state=IDLE, data_out=0, mem_done=0, busy=0, addr_err=0, count=0. RAM contents not reset.
// - FSM IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE: at a clk edge with (mem_read|mem_write)=1:
//     capture address, data_in and op (write if mem_write=1, else read);
//     busy<=1; count<=LATENCY-1; go to ACCESS.
// - Simultaneous mem_read and mem_write: treated as a write. No read data is returned and data_out is unchanged.
// - ACCESS: count decrements each edge. The edge on which count==0 performs the access:
//     write: ram[addr]<=captured data.
//     read: data_out<=ram[addr].
//   The same edge sets mem_done<=1 and busy<=0 and goes to DONE.
//   With LATENCY=1 the access happens on the edge after accept.
// - Latency: a request accepted at edge k gives mem_done=1 after edge k+LATENCY. Read data is valid in that same cycle.
// - Range check: addr is legal iff address[31:ADDR_W]==0.
//   Illegal: no RAM write; a read loads data_out<=0; addr_err<=1 together with mem_done.
// - DONE: mem_done stays 1 while either strobe is high (no re-trigger). Once both strobes are low:
//     mem_done<=0, addr_err<=0, go to IDLE.
//   Earliest next accept is the following edge.
// - Changes to address, data_in or the op strobes after accept are ignored until the next IDLE.
// - data_out holds the last read result until the next completed read, including across writes.
// - Reset mid-ACCESS aborts the operation: no RAM write occurs unless its access edge already happened.
// - Top word (addr 2**ADDR_W-1) is legal. There is no wrap: address 2**ADDR_W is out of range.
// TESTING
// - Basic write/read: write 0xDEADBEEF @0x055; drop strobes; read @0x055 -> data_out=0xDEADBEEF.
//   mem_done rises exactly LATENCY edges after each accept.
// - Latency sweep: LATENCY=1 and LATENCY=4.
//   Read accepted at edge k -> mem_done=1 after edge k+1 and k+4 respectively; busy=1 in the cycles between.
// - Held strobe: keep mem_read=1 for 10 cycles after done -> mem_done stays 1, exactly one access occurs.
//   Dropping the strobe -> mem_done=0 the next cycle.
// - Out of range: write 0x12345678 @0x200 -> addr_err=1 with done, ram unchanged.
//   Read @0x200 -> data_out=0, addr_err=1.
//   Read @0x1FF after writing 0xA5A5A5A5 -> 0xA5A5A5A5, addr_err=0.
// - Read+write both high: mem_read=mem_write=1 with data 0x0000BEEF @0x010 -> written.
//   data_out keeps its previous value; a later read @0x010 returns 0x0000BEEF.
// - Reset mid-access (LATENCY=3): accept a write of 0xCAFEF00D @0x020; assert clr=0 one cycle later
//   -> outputs 0 immediately (async), state IDLE, and a read @0x020 does not return 0xCAFEF00D.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath-to-memory request/response bundle with done handshake
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_done;
  logic        busy;
  logic        addr_err;
  modport master (
    output mem_read, mem_write, address, data_in,
    input  data_out, mem_done, busy, addr_err
  );
  modport slave (
    input  mem_read, mem_write, address, data_in,
    output data_out, mem_done, busy, addr_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word RAM answering MAR/MDR requests over a 4-phase req/done handshake
module mem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             clr,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state, state_nx;
  logic [3:0]  count;
  logic [31:0] addr_q, data_q, data_out_q;
  logic        wr_q, done_q, busy_q, err_q;
  logic [31:0] ram [2**ADDR_W];
  logic        req, accept, fire, release_q, legal;
  assign req       = bus.mem_read | bus.mem_write;
  assign accept    = state == IDLE && req;
  assign fire      = state == ACCESS && count == 4'd0;
  assign release_q = state == DONE && !req;
  assign legal     = addr_q[31:ADDR_W] == '0;
  assign bus.data_out = data_out_q;
  assign bus.mem_done = done_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = err_q;
  // state register
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  // next state: DONE is held until both strobes drop so a held strobe never re-triggers
  always_comb begin
    state_nx = state;
    if (accept)         state_nx = ACCESS;
    else if (fire)      state_nx = DONE;
    else if (release_q) state_nx = IDLE;
  end
  // request capture, latency countdown, read return and handshake outputs
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      count      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.address;
      data_q <= bus.data_in;
      wr_q   <= bus.mem_write;
      busy_q <= 1'b1;
      count  <= 4'(LATENCY - 1);
    end else if (state == ACCESS) begin
      count <= count - 4'd1;
      if (fire) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
        err_q  <= !legal;
        if (!wr_q) data_out_q <= legal ? ram[addr_q[ADDR_W-1:0]] : '0;
      end
    end else if (release_q) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end
  // RAM array has no reset; writes land only on the access edge of a legal write
  always_ff @(posedge clk)
    if (fire && wr_q && legal) ram[addr_q[ADDR_W-1:0]] <= data_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench over four responders with LATENCY 1..4
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, din = '0;
  int          sel = 0;
  logic [3:0]  done_a, busy_a, err_a;
  logic [31:0] dout_a [4];
  int          total = 0, bad = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    bit          chk;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model [4][512];
  logic [31:0] last [4] = '{default: 32'h0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : u
    mem_responder_if bus();
    assign bus.mem_read  = rd && sel == g;
    assign bus.mem_write = wr && sel == g;
    assign bus.address   = addr;
    assign bus.data_in   = din;
    assign done_a[g] = bus.mem_done;
    assign busy_a[g] = bus.busy;
    assign err_a[g]  = bus.addr_err;
    assign dout_a[g] = bus.data_out;
    mem_responder #(.ADDR_W(9), .LATENCY(g + 1)) dut (.clk(clk), .clr(clr), .bus(bus));
  end

  task automatic expect_op(input int s, input bit w, input logic [31:0] a, input logic [31:0] d, input bit chk);
    exp_t e;
    logic [8:0] idx;
    idx   = a[8:0];
    e.err = a[31:9] != 0;
    e.chk = chk;
    if (w) begin
      if (!e.err) model[s][idx] = d;
      e.dout = last[s];
    end else begin
      e.dout = e.err ? 32'h0 : model[s][idx];
      last[s] = e.dout;
    end
    sb.push_back(e);
  endtask

  task automatic run_op(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input bit chk);
    exp_t e;
    int   n;
    sel = s;
    expect_op(s, w, a, d, chk);
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    @(posedge clk); #1;
    addr = $urandom; din = $urandom;
    n = 0;
    while (!done_a[s] && n < 40) begin
      total++;
      if (busy_a[s] !== 1'b1) begin bad++; $display("FAIL busy_during_access dut%0d: got %b want 1", s, busy_a[s]); end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != s + 1) begin bad++; $display("FAIL latency dut%0d: got %0d edges want %0d", s, n, s + 1); end
    e = sb.pop_front();
    total++;
    if (e.chk && dout_a[s] !== e.dout) begin bad++; $display("FAIL data_out dut%0d @%h: got %h want %h", s, a, dout_a[s], e.dout); end
    total++;
    if (err_a[s] !== e.err || busy_a[s] !== 1'b0) begin
      bad++; $display("FAIL err_busy_at_done dut%0d @%h: got err=%b busy=%b want err=%b busy=0", s, a, err_a[s], busy_a[s], e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (done_a[s] !== 1'b1 || busy_a[s] !== 1'b0) begin
        bad++; $display("FAIL held_done dut%0d cyc%0d: got done=%b busy=%b want done=1 busy=0", s, i, done_a[s], busy_a[s]);
      end
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done_a[s] !== 1'b0 || err_a[s] !== 1'b0) begin
      bad++; $display("FAIL release dut%0d: got done=%b err=%b want 0 0", s, done_a[s], err_a[s]);
    end
  endtask

  task automatic test_reset();
    #2 clr = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      total++;
      if (done_a[s] !== 1'b0 || busy_a[s] !== 1'b0 || err_a[s] !== 1'b0 || dout_a[s] !== 32'h0) begin
        bad++; $display("FAIL reset dut%0d: got done=%b busy=%b err=%b dout=%h want all 0", s, done_a[s], busy_a[s], err_a[s], dout_a[s]);
      end
    end
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_basic();
    run_op(1, 0, 1, 32'h055, 32'hDEADBEEF, 0, 1);
    run_op(1, 1, 0, 32'h055, 32'h0, 0, 1);
  endtask

  task automatic test_latency();
    run_op(0, 0, 1, 32'h033, 32'h13572468, 0, 1);
    run_op(0, 1, 0, 32'h033, 32'h0, 0, 1);
    run_op(3, 0, 1, 32'h044, 32'h24681357, 0, 1);
    run_op(3, 1, 0, 32'h044, 32'h0, 0, 1);
  endtask

  task automatic test_held();
    run_op(1, 1, 0, 32'h055, 32'h0, 10, 1);
  endtask

  task automatic test_range();
    run_op(1, 0, 1, 32'h000, 32'h600DF00D, 0, 1);
    run_op(1, 0, 1, 32'h200, 32'h12345678, 0, 1);
    run_op(1, 1, 0, 32'h200, 32'h0, 0, 1);
    run_op(1, 1, 0, 32'h000, 32'h0, 0, 1);
    run_op(1, 0, 1, 32'h1FF, 32'hA5A5A5A5, 0, 1);
    run_op(1, 1, 0, 32'h1FF, 32'h0, 0, 1);
    run_op(1, 1, 0, 32'h8000_0055, 32'h0, 0, 1);
  endtask

  task automatic test_both();
    run_op(1, 1, 0, 32'h055, 32'h0, 0, 1);
    run_op(1, 1, 1, 32'h010, 32'h0000BEEF, 0, 1);
    run_op(1, 1, 0, 32'h010, 32'h0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_op(1, 0, 1, 32'h100 + i, $urandom, 0, 1);
    for (int i = 3; i >= 0; i--) run_op(1, 1, 0, 32'h100 + i, 32'h0, 0, 1);
  endtask

  task automatic test_reset_mid();
    run_op(2, 0, 1, 32'h021, 32'h11111111, 0, 1);
    run_op(2, 1, 0, 32'h021, 32'h0, 0, 1);
    sel = 2;
    @(negedge clk);
    wr = 1'b1; addr = 32'h020; din = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    total++;
    if (done_a[2] !== 1'b0 || busy_a[2] !== 1'b0 || err_a[2] !== 1'b0 || dout_a[2] !== 32'h0) begin
      bad++; $display("FAIL reset_mid dut2: got done=%b busy=%b err=%b dout=%h want all 0", done_a[2], busy_a[2], err_a[2], dout_a[2]);
    end
    wr = 1'b0;
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    for (int s = 0; s < 4; s++) last[s] = 32'h0;
    run_op(2, 1, 0, 32'h020, 32'h0, 0, 0);
    total++;
    if (dout_a[2] === 32'hCAFEF00D) begin bad++; $display("FAIL aborted_write dut2: got %h want not CAFEF00D", dout_a[2]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_held();
    test_range();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
